// File: rtl/sevenseg_scan_arbiter_if.sv
// sevenseg_scan_arbiter_if: request/pattern inputs and display/grant outputs of the scan arbiter
interface sevenseg_scan_arbiter_if;
  logic [3:0]   req;
  logic [223:0] pat;
  logic [7:0]   AN;
  logic [6:0]   CA;
  logic [3:0]   grant;
  logic         frame_done;
  modport master (output req, pat, input AN, CA, grant, frame_done);
  modport slave  (input req, pat, output AN, CA, grant, frame_done);
endinterface

// File: rtl/sevenseg_scan_arbiter.sv
// sevenseg_scan_arbiter: round-robin sharing of an 8-digit seven-segment display with digit scanning
module sevenseg_scan_arbiter #(
  parameter int CLK_DIV     = 100000,
  parameter int HOLD_FRAMES = 64
) (
  input logic clk,
  input logic rst,
  sevenseg_scan_arbiter_if.slave io_disp
);
  localparam int TW = $clog2(CLK_DIV);
  localparam int HW = $clog2(HOLD_FRAMES + 1);
  typedef enum logic {IDLE, OWN} state_t;
  state_t         r_state;
  logic [TW-1:0]  r_tcnt;
  logic [2:0]     r_dig;
  logic [HW-1:0]  r_held;
  logic [1:0]     r_last;
  logic [7:0]     r_an;
  logic [6:0]     r_ca;
  logic [3:0]     r_grant;
  logic           r_fd;
  logic           w_tick, w_own_req, w_others, w_keep;
  logic [1:0]     w_win, w_new;
  logic [2:0]     w_dig_nx;
  logic [6:0]     w_ca_step, w_ca_load;
  assign w_tick    = r_tcnt == TW'(CLK_DIV - 1);
  assign w_own_req = io_disp.req[r_last];
  assign w_others  = |(io_disp.req & ~r_grant);
  assign w_keep    = w_own_req && (!w_others || 32'(r_held) + 1 < HOLD_FRAMES);
  assign w_new     = (r_state == OWN && w_keep) ? r_last : w_win;
  assign w_dig_nx  = r_dig + 3'd1;
  assign w_ca_step = io_disp.pat[8'({r_last, w_dig_nx}) * 8'd7 +: 7];
  assign w_ca_load = io_disp.pat[8'({w_new, 3'd0}) * 8'd7 +: 7];
  // search last+1..last+3 then last; the nearest requester after the pointer wins
  always_comb begin
    w_win = r_last;
    for (int k = 3; k >= 1; k--)
      if (io_disp.req[r_last + 2'(k)]) w_win = r_last + 2'(k);
  end
  // arbitration FSM, digit scan and registered display outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_tcnt  <= '0;
      r_dig   <= '0;
      r_held  <= '0;
      r_last  <= 2'd3;
      r_an    <= 8'hFF;
      r_ca    <= 7'h7F;
      r_grant <= '0;
      r_fd    <= 1'b0;
    end else begin
      r_fd   <= r_state == OWN && w_tick && r_dig == 3'd7;
      r_tcnt <= (r_state == IDLE || w_tick) ? '0 : r_tcnt + 1'b1;
      if (r_state == IDLE) begin
        if (|io_disp.req) begin
          r_state <= OWN;
          r_grant <= 4'b1 << w_win;
          r_last  <= w_win;
          r_dig   <= '0;
          r_held  <= '0;
          r_an    <= 8'hFE;
          r_ca    <= w_ca_load;
        end
      end else if (w_tick && r_dig != 3'd7) begin
        r_dig <= w_dig_nx;
        r_an  <= ~(8'b1 << w_dig_nx);
        r_ca  <= w_ca_step;
      end else if (w_tick) begin
        r_dig <= '0;
        if (!(|io_disp.req)) begin
          r_state <= IDLE;
          r_grant <= '0;
          r_an    <= 8'hFF;
          r_ca    <= 7'h7F;
        end else begin
          r_grant <= 4'b1 << w_new;
          r_last  <= w_new;
          r_held  <= (w_keep && w_others) ? r_held + 1'b1 : '0;
          r_an    <= 8'hFE;
          r_ca    <= w_ca_load;
        end
      end
    end
  end
  assign io_disp.AN         = r_an;
  assign io_disp.CA         = r_ca;
  assign io_disp.grant      = r_grant;
  assign io_disp.frame_done = r_fd;
endmodule

// File: tb/tb_sevenseg_scan_arbiter.sv
// tb_sevenseg_scan_arbiter: random and directed stimulus on two arbiters (hold 2 and hold 1) against a frame-level model
module tb_sevenseg_scan_arbiter;
  localparam int CD = 4;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req = '0;
  logic [223:0] pat;
  int n_chk = 0;
  int n_fail = 0;
  int m_own[2], m_last[2], m_pos[2], m_held[2];
  logic m_fd[2];
  logic [6:0] m_ca[2];
  sevenseg_scan_arbiter_if b0 ();
  sevenseg_scan_arbiter_if b1 ();
  assign b0.req = req;
  assign b0.pat = pat;
  assign b1.req = req;
  assign b1.pat = pat;
  sevenseg_scan_arbiter #(.CLK_DIV(CD), .HOLD_FRAMES(2)) dut0 (.clk(clk), .rst(rst), .io_disp(b0.slave));
  sevenseg_scan_arbiter #(.CLK_DIV(CD), .HOLD_FRAMES(1)) dut1 (.clk(clk), .rst(rst), .io_disp(b1.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  function automatic int pick(input int last, input logic [3:0] r);
    for (int i = 1; i <= 4; i++)
      if (r[(last + i) % 4]) return (last + i) % 4;
    return -1;
  endfunction
  function automatic logic [6:0] pget(input int r, input int d);
    return pat[(r * 8 + d) * 7 +: 7];
  endfunction
  task automatic step(input int k);
    int h;
    logic [3:0] others;
    h = (k == 0) ? 2 : 1;
    if (rst) begin
      m_own[k] = -1; m_last[k] = 3; m_pos[k] = 0; m_held[k] = 0; m_fd[k] = 1'b0; m_ca[k] = 7'h7F;
      return;
    end
    m_fd[k] = 1'b0;
    if (m_own[k] < 0) begin
      if (req != 0) begin
        m_own[k] = pick(m_last[k], req);
        m_last[k] = m_own[k];
        m_pos[k] = 0;
        m_held[k] = 0;
      end
    end else begin
      m_pos[k]++;
      if (m_pos[k] == 8 * CD) begin
        m_pos[k] = 0;
        m_fd[k] = 1'b1;
        others = req & ~(4'b1 << m_own[k]);
        if (req[m_own[k]] && others == 0) m_held[k] = 0;
        else if (req[m_own[k]] && m_held[k] + 1 < h) m_held[k]++;
        else if (req != 0) begin
          m_own[k] = pick(m_last[k], req);
          m_last[k] = m_own[k];
          m_held[k] = 0;
        end else begin
          m_own[k] = -1;
          m_ca[k] = 7'h7F;
        end
      end
    end
    if (m_own[k] >= 0 && m_pos[k] % CD == 0) m_ca[k] = pget(m_own[k], m_pos[k] / CD);
  endtask
  task automatic cyc();
    @(posedge clk);
    step(0);
    step(1);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      logic [7:0] an;
      logic [6:0] ca;
      logic [3:0] gr;
      logic fd;
      an = k ? b1.AN : b0.AN;
      ca = k ? b1.CA : b0.CA;
      gr = k ? b1.grant : b0.grant;
      fd = k ? b1.frame_done : b0.frame_done;
      check($sformatf("dut%0d AN", k), 32'(an), m_own[k] < 0 ? 32'hFF : 32'(8'(~(8'b1 << (m_pos[k] / CD)))));
      check($sformatf("dut%0d CA", k), 32'(ca), m_own[k] < 0 ? 32'h7F : 32'(m_ca[k]));
      check($sformatf("dut%0d grant", k), 32'(gr), m_own[k] < 0 ? 32'h0 : 32'(4'b1 << m_own[k]));
      check($sformatf("dut%0d frame_done", k), 32'(fd), 32'(m_fd[k]));
    end
  endtask
  task automatic run(input int n);
    repeat (n) cyc();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    run(2);
    rst = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 32; i++) pat[i * 7 +: 7] = 7'(8'h10 + i);
    req = 4'b0000;
    do_reset();
    run(100);
    req = 4'b0001;
    run(100);
    req = 4'b0000;
    do_reset();
    req = 4'b0101;
    run(300);
    do_reset();
    req = 4'b1111;
    run(300);
    req = 4'b0000;
    do_reset();
    req = 4'b0001;
    run(1 + 3 * CD);
    req = 4'b0000;
    run(40);
    do_reset();
    req = 4'b0001;
    run(1 + 3 * CD);
    req = 4'b1000;
    run(40);
    req = 4'b0001;
    do_reset();
    run(1 + 5 * CD + 1);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    req = 4'b0010;
    run(50);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) pat[$urandom_range(0, 31) * 7 +: 7] = 7'($urandom);
      rst = ($urandom_range(0, 499) == 0);
      cyc();
    end
    rst = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
